// File: rtl/ciq_pkg.sv
// ciq_pkg: shared constants, types and helpers for the CIQ allocation/select slice
package ciq_pkg;
  localparam int CIQ_DEPTH = 16;
  localparam int DECODE_NUM = 4;
  localparam int ISSUE_NUM = 4;
  localparam int ADDR_W = 4;
  localparam int ISSUE_W = $clog2(ISSUE_NUM);
  typedef logic [ADDR_W-1:0] ciq_addr_t;
  typedef logic [ADDR_W:0] ciq_cnt_t;
  function automatic ciq_cnt_t popcount(input logic [CIQ_DEPTH-1:0] v);
    popcount = '0;
    for (int k = 0; k < CIQ_DEPTH; k++) popcount = popcount + ciq_cnt_t'(v[k]);
  endfunction
  function automatic ciq_addr_t find_nth_free(input logic [CIQ_DEPTH-1:0] v, input ciq_cnt_t n);
    ciq_cnt_t c;
    c = '0;
    find_nth_free = '0;
    for (int k = 0; k < CIQ_DEPTH; k++)
      if (!v[k]) begin
        if (c == n) find_nth_free = ciq_addr_t'(k);
        c = c + 1'b1;
      end
  endfunction
endpackage

// File: rtl/ciq_age_matrix.sv
// ciq_age_matrix: relative age of CIQ entries (age[k][m] = m older than k) and oldest-first multi-port pick
module ciq_age_matrix
  import ciq_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [CIQ_DEPTH-1:0]         valid,
  input  logic [DECODE_NUM-1:0]        alloc_valid,
  input  logic [DECODE_NUM*ADDR_W-1:0] alloc_addr,
  input  logic [CIQ_DEPTH-1:0]         cand,
  output logic [ISSUE_NUM*ADDR_W-1:0]  sel_addr,
  output logic [ISSUE_NUM-1:0]         sel_valid
);
  logic [CIQ_DEPTH-1:0] age [CIQ_DEPTH];
  logic [CIQ_DEPTH-1:0] new_row [DECODE_NUM];
  logic [CIQ_DEPTH-1:0] alloc_mask;
  ciq_cnt_t older;
  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      new_row[i] = valid | alloc_mask;
      if (alloc_valid[i]) alloc_mask[alloc_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end
  // later slots overwrite the column clear of earlier slots, so same-cycle order is kept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < CIQ_DEPTH; k++) age[k] <= '0;
    else if (flush)
      for (int k = 0; k < CIQ_DEPTH; k++) age[k] <= '0;
    else
      for (int i = 0; i < DECODE_NUM; i++)
        if (alloc_valid[i]) begin
          age[alloc_addr[i*ADDR_W +: ADDR_W]] <= new_row[i];
          for (int k = 0; k < CIQ_DEPTH; k++) age[k][alloc_addr[i*ADDR_W +: ADDR_W]] <= 1'b0;
        end
  // valid entries form a total order, so the number of older cands is the port index
  always_comb begin
    sel_addr = '0;
    sel_valid = '0;
    older = '0;
    for (int k = 0; k < CIQ_DEPTH; k++) begin
      older = popcount(age[k] & cand);
      if (cand[k] && older < ciq_cnt_t'(ISSUE_NUM)) begin
        sel_valid[older[ISSUE_W-1:0]] = 1'b1;
        sel_addr[older[ISSUE_W-1:0]*ADDR_W +: ADDR_W] = ciq_addr_t'(k);
      end
    end
  end
endmodule

// File: rtl/ciq_alloc_select.sv
// ciq_alloc_select: CIQ slot allocator and oldest-first issue select; CIQ_ALLOC_PARTIAL_EN enables partial in-order allocation
module ciq_alloc_select
  import ciq_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [DECODE_NUM-1:0]        alloc_req,
  output logic [DECODE_NUM*ADDR_W-1:0] free_addr,
  output logic [DECODE_NUM-1:0]        free_valid,
  output logic                         alloc_stall,
  input  logic [CIQ_DEPTH-1:0]         entry_rdy,
  output logic [ISSUE_NUM*ADDR_W-1:0]  arbit_addr,
  output logic [ISSUE_NUM-1:0]         arbit_grant,
  output logic [ADDR_W:0]              iq_count
);
  logic [CIQ_DEPTH-1:0] valid, cand, alloc_mask, issue_mask, valid_nxt;
  logic [ISSUE_NUM*ADDR_W-1:0] sel_addr;
  logic [ISSUE_NUM-1:0] sel_valid;
  logic [DECODE_NUM-1:0] grant;
  ciq_cnt_t free_cnt, rank;
  logic dup;
  assign cand = valid & entry_rdy;
  assign free_cnt = ciq_cnt_t'(CIQ_DEPTH) - popcount(valid);
  always_comb begin
    rank = '0;
    free_addr = '0;
    grant = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      free_addr[i*ADDR_W +: ADDR_W] = find_nth_free(valid, rank);
      grant[i] = alloc_req[i] && rank < free_cnt;
      rank = rank + ciq_cnt_t'(alloc_req[i]);
    end
  end
`ifdef CIQ_ALLOC_PARTIAL_EN
  assign free_valid = (rst_n && !flush) ? grant : '0;
`else
  assign free_valid = (rst_n && !flush && rank <= free_cnt) ? alloc_req : '0;
`endif
  assign alloc_stall = rst_n && rank > free_cnt;
  always_comb begin
    alloc_mask = '0;
    issue_mask = '0;
    for (int i = 0; i < DECODE_NUM; i++)
      if (free_valid[i]) alloc_mask[free_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    for (int j = 0; j < ISSUE_NUM; j++)
      if (sel_valid[j]) issue_mask[sel_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
  end
  assign valid_nxt = (valid & ~issue_mask) | alloc_mask;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      iq_count <= '0;
      arbit_grant <= '0;
      arbit_addr <= '0;
    end else if (flush) begin
      valid <= '0;
      iq_count <= '0;
      arbit_grant <= '0;
      arbit_addr <= '0;
    end else begin
      valid <= valid_nxt;
      iq_count <= popcount(valid_nxt);
      arbit_grant <= sel_valid;
      arbit_addr <= sel_addr;
    end
  ciq_age_matrix u_age (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .valid(valid),
    .alloc_valid(free_valid),
    .alloc_addr(free_addr),
    .cand(cand),
    .sel_addr(sel_addr),
    .sel_valid(sel_valid)
  );
  always_comb begin
    dup = 1'b0;
    for (int j = 0; j < ISSUE_NUM; j++)
      for (int l = j + 1; l < ISSUE_NUM; l++)
        if (arbit_grant[j] && arbit_grant[l] &&
            arbit_addr[j*ADDR_W +: ADDR_W] == arbit_addr[l*ADDR_W +: ADDR_W]) dup = 1'b1;
  end
  assert property (@(posedge clk) disable iff (!rst_n) !dup);
endmodule

// File: tb/tb_ciq_alloc_select.sv
// tb_ciq_alloc_select: directed scenarios plus randomized run against an age-ordered queue model
module tb_ciq_alloc_select;
  import ciq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic [3:0] alloc_req = 4'b1111;
  logic [15:0] entry_rdy = '0;
  logic [15:0] free_addr;
  logic [3:0] free_valid;
  logic alloc_stall;
  logic [15:0] arbit_addr;
  logic [3:0] arbit_grant;
  logic [4:0] iq_count;
  int checks = 0;
  int failures = 0;
  int q[$];
  logic [3:0] e_fv, e_gnt;
  logic e_stall;
  logic [15:0] e_fa, e_addr;
  int e_cnt;

  ciq_alloc_select dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_req(alloc_req),
    .free_addr(free_addr), .free_valid(free_valid), .alloc_stall(alloc_stall),
    .entry_rdy(entry_rdy), .arbit_addr(arbit_addr), .arbit_grant(arbit_grant),
    .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [3:0] a, input logic [15:0] r);
    flush = f;
    alloc_req = a;
    entry_rdy = r;
  endtask

  task automatic clear();
    drive(1'b1, 4'b0, 16'h0);
    tick();
    drive(1'b0, 4'b0, 16'h0);
  endtask

  function automatic bit occ(int k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // q holds occupied entries, oldest first
  task automatic model_comb();
    int fl[$];
    int n;
    for (int k = 0; k < 16; k++) if (!occ(k)) fl.push_back(k);
    e_fv = '0;
    e_fa = '0;
    n = 0;
    e_stall = $countones(alloc_req) > fl.size();
    for (int i = 0; i < 4; i++)
      if (alloc_req[i]) begin
        if (n < fl.size()) begin
          e_fv[i] = 1'b1;
          e_fa[i*4 +: 4] = 4'(fl[n]);
        end
        n++;
      end
`ifndef CIQ_ALLOC_PARTIAL_EN
    if (e_stall) e_fv = '0;
`endif
    if (flush) e_fv = '0;
  endtask

  task automatic model_clock();
    int picked[$];
    int keep[$];
    e_gnt = '0;
    e_addr = '0;
    if (flush) q.delete();
    else begin
      foreach (q[i])
        if (entry_rdy[q[i]] && picked.size() < 4) picked.push_back(q[i]);
        else keep.push_back(q[i]);
      foreach (picked[j]) begin
        e_gnt[j] = 1'b1;
        e_addr[j*4 +: 4] = 4'(picked[j]);
      end
      for (int i = 0; i < 4; i++) if (e_fv[i]) keep.push_back(int'(e_fa[i*4 +: 4]));
      q = keep;
    end
    e_cnt = q.size();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #6;
    checks++; if (arbit_grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b want=0000", arbit_grant); end
    checks++; if (arbit_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h want=0000", arbit_addr); end
    checks++; if (iq_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", iq_count); end
    checks++; if (free_valid !== 4'b0) begin failures++; $display("FAIL reset_free_valid got=%b want=0000", free_valid); end
    checks++; if (alloc_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", alloc_stall); end
    #5 rst_n = 1'b1;
    drive(1'b0, 4'b0, 16'h0);
    tick();
  endtask

  task automatic test_reset_alloc();
    drive(1'b0, 4'b1111, 16'h0);
    #3;
    checks++; if (free_valid !== 4'b1111) begin failures++; $display("FAIL first_alloc_valid got=%b want=1111", free_valid); end
    checks++; if (free_addr !== 16'h3210) begin failures++; $display("FAIL first_alloc_addr got=%h want=3210", free_addr); end
    checks++; if (alloc_stall !== 1'b0) begin failures++; $display("FAIL first_alloc_stall got=%b want=0", alloc_stall); end
    tick();
    checks++; if (iq_count !== 5'd4) begin failures++; $display("FAIL first_alloc_count got=%0d want=4", iq_count); end
    clear();
  endtask

  task automatic test_latency_age();
    drive(1'b0, 4'b0001, 16'h0001);
    tick();
    checks++; if (arbit_grant !== 4'b0) begin failures++; $display("FAIL new_entry_early got=%b want=0000", arbit_grant); end
    drive(1'b0, 4'b0, 16'h0001);
    tick();
    checks++; if (arbit_grant !== 4'b0001 || arbit_addr !== 16'h0) begin failures++; $display("FAIL new_entry_grant got=%b/%h want=0001/0000", arbit_grant, arbit_addr); end
    clear();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0001, 16'h0);
      tick();
    end
    checks++; if (iq_count !== 5'd4) begin failures++; $display("FAIL age_fill_count got=%0d want=4", iq_count); end
    drive(1'b0, 4'b0, 16'b1010);
    tick();
    checks++; if (arbit_grant !== 4'b0011 || arbit_addr !== 16'h0031) begin failures++; $display("FAIL age_order got=%b/%h want=0011/0031", arbit_grant, arbit_addr); end
    checks++; if (iq_count !== 5'd2) begin failures++; $display("FAIL age_count got=%0d want=2", iq_count); end
    tick();
    checks++; if (arbit_grant !== 4'b0 || arbit_addr !== 16'h0) begin failures++; $display("FAIL age_regrant got=%b/%h want=0000/0000", arbit_grant, arbit_addr); end
    clear();
  endtask

  task automatic test_more_ready();
    int seq[6] = '{5, 2, 7, 0, 9, 4};
    drive(1'b0, 4'b1111, 16'h0);
    tick();
    tick();
    drive(1'b0, 4'b0011, 16'h0);
    tick();
    checks++; if (iq_count !== 5'd10) begin failures++; $display("FAIL more_fill_count got=%0d want=10", iq_count); end
    foreach (seq[s]) begin
      drive(1'b0, 4'b0, 16'(1 << seq[s]));
      tick();
      drive(1'b0, 4'b0001, 16'h0);
      #3;
      checks++; if (free_valid !== 4'b0001 || free_addr[3:0] !== 4'(seq[s])) begin failures++; $display("FAIL more_realloc got=%b/%0d want=0001/%0d", free_valid, free_addr[3:0], seq[s]); end
      tick();
    end
    drive(1'b0, 4'b0, 16'h02B5);
    tick();
    checks++; if (arbit_grant !== 4'b1111 || arbit_addr !== 16'h0725) begin failures++; $display("FAIL more_first got=%b/%h want=1111/0725", arbit_grant, arbit_addr); end
    checks++; if (iq_count !== 5'd6) begin failures++; $display("FAIL more_first_count got=%0d want=6", iq_count); end
    tick();
    checks++; if (arbit_grant !== 4'b0011 || arbit_addr !== 16'h0049) begin failures++; $display("FAIL more_second got=%b/%h want=0011/0049", arbit_grant, arbit_addr); end
    checks++; if (iq_count !== 5'd4) begin failures++; $display("FAIL more_second_count got=%0d want=4", iq_count); end
    tick();
    checks++; if (arbit_grant !== 4'b0) begin failures++; $display("FAIL more_empty got=%b want=0000", arbit_grant); end
    clear();
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111, 16'h0);
      tick();
    end
    drive(1'b0, 4'b0011, 16'h0);
    tick();
    drive(1'b0, 4'b0111, 16'h0);
    #3;
    checks++; if (alloc_stall !== 1'b1) begin failures++; $display("FAIL short_stall got=%b want=1", alloc_stall); end
`ifdef CIQ_ALLOC_PARTIAL_EN
    checks++; if (free_valid !== 4'b0011 || free_addr[7:0] !== 8'hFE) begin failures++; $display("FAIL short_partial got=%b/%h want=0011/fe", free_valid, free_addr[7:0]); end
    tick();
`else
    checks++; if (free_valid !== 4'b0) begin failures++; $display("FAIL short_all_or_none got=%b want=0000", free_valid); end
    tick();
    checks++; if (iq_count !== 5'd14) begin failures++; $display("FAIL short_count got=%0d want=14", iq_count); end
    drive(1'b0, 4'b0011, 16'h0);
    tick();
`endif
    checks++; if (iq_count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d want=16", iq_count); end
    drive(1'b0, 4'b1000, 16'h0);
    #3;
    checks++; if (alloc_stall !== 1'b1 || free_valid !== 4'b0) begin failures++; $display("FAIL full_stall got=%b/%b want=1/0000", alloc_stall, free_valid); end
    clear();
  endtask

  task automatic test_flush_collision();
    drive(1'b0, 4'b0111, 16'h0);
    tick();
    drive(1'b1, 4'b1111, 16'h0007);
    #3;
    checks++; if (free_valid !== 4'b0) begin failures++; $display("FAIL flush_free_valid got=%b want=0000", free_valid); end
    tick();
    checks++; if (iq_count !== 5'd0 || arbit_grant !== 4'b0) begin failures++; $display("FAIL flush_state got=%0d/%b want=0/0000", iq_count, arbit_grant); end
    drive(1'b0, 4'b0, 16'h0007);
    tick();
    checks++; if (arbit_grant !== 4'b0) begin failures++; $display("FAIL flush_after_grant got=%b want=0000", arbit_grant); end
    drive(1'b0, 4'b1111, 16'h0);
    #3;
    checks++; if (free_valid !== 4'b1111 || free_addr !== 16'h3210) begin failures++; $display("FAIL flush_realloc got=%b/%h want=1111/3210", free_valid, free_addr); end
    tick();
    clear();
  endtask

  task automatic test_async_reset();
    drive(1'b0, 4'b1111, 16'h0);
    tick();
    tick();
    drive(1'b0, 4'b0, 16'h0001);
    tick();
    checks++; if (arbit_grant !== 4'b0001 || iq_count !== 5'd7) begin failures++; $display("FAIL pre_reset got=%b/%0d want=0001/7", arbit_grant, iq_count); end
    drive(1'b0, 4'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (arbit_grant !== 4'b0 || iq_count !== 5'd0 || arbit_addr !== 16'h0) begin failures++; $display("FAIL async_reset got=%b/%0d/%h want=0000/0/0000", arbit_grant, iq_count, arbit_addr); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    clear();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic [15:0] m;
      drive($urandom_range(0, 19) == 0, 4'($urandom), 16'($urandom & $urandom));
      model_comb();
      #3;
      m = {{4{e_fv[3]}}, {4{e_fv[2]}}, {4{e_fv[1]}}, {4{e_fv[0]}}};
      checks++; if (free_valid !== e_fv || alloc_stall !== e_stall) begin failures++; $display("FAIL rand_alloc cyc=%0d got=%b/%b want=%b/%b", c, free_valid, alloc_stall, e_fv, e_stall); end
      checks++; if ((free_addr & m) !== (e_fa & m)) begin failures++; $display("FAIL rand_free_addr cyc=%0d got=%h want=%h", c, free_addr & m, e_fa & m); end
      model_clock();
      tick();
      checks++; if (arbit_grant !== e_gnt || arbit_addr !== e_addr || iq_count !== 5'(e_cnt)) begin failures++; $display("FAIL rand_select cyc=%0d got=%b/%h/%0d want=%b/%h/%0d", c, arbit_grant, arbit_addr, iq_count, e_gnt, e_addr, e_cnt); end
    end
    drive(1'b0, 4'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_reset_alloc();
    test_latency_age();
    test_more_ready();
    test_full_stall();
    test_flush_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
